// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file and its pending-write scoreboard.
package regfile_pkg;

  localparam int ZERO_REG       = 0;
  localparam int PEND_W_DEFAULT = 2;

  typedef logic [PEND_W_DEFAULT-1:0] pend_cnt_t;

  // Address width that never collapses to zero bits for tiny register files.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_pend_cnt.sv
// Saturating up/down pending-write counter for one architectural register.
module regfile_pend_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat,
  output logic         nz
);

  logic inc_ok;
  logic dec_ok;

  assign sat    = (cnt == {W{1'b1}});
  assign nz     = (cnt != '0);
  assign inc_ok = inc && !sat;
  assign dec_ok = dec && nz;

  // Matching inc and dec cancel; dec at zero is ignored so the count never wraps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc_ok && !dec_ok) begin
      cnt <= cnt + 1'b1;
    end else if (dec_ok && !inc_ok) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with combinational read ports, optional writeback bypass
// and a per-register pending-write scoreboard for issue-stage hazard stalls.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int  XLEN   = 32,
   parameter int  NREGS  = 16,
   parameter int  NRD    = 2,
   parameter int  BYPASS = 1,
   parameter int  PEND_W = 2,
   localparam int AW     = clog2_safe(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD*AW-1:0]     rd_addr,
   output logic [NRD*XLEN-1:0]   rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic                  iss_valid,
   input  logic [AW-1:0]         iss_addr,
   output logic                  iss_ready,
   input  logic                  wb_valid,
   input  logic [AW-1:0]         wb_addr,
   input  logic [XLEN-1:0]       wb_data,
   input  logic                  wb_retire,
   input  logic                  flush,
   output logic [NREGS*XLEN-1:0] dbg_regs
);

   logic [XLEN-1:0]   regs_q [NREGS];
   logic [PEND_W-1:0] cnt    [NREGS];
   logic [NREGS-1:0]  sat;
   logic [NREGS-1:0]  nz;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      end else if (wb_valid && wb_addr != AW'(ZERO_REG)) begin
         regs_q[wb_addr] <= wb_data;
      end
   end

   assign cnt[0] = '0;
   assign sat[0] = 1'b0;
   assign nz[0]  = 1'b0;

   for (genvar r = 1; r < NREGS; r++) begin : g_cnt
      logic inc_r;
      logic dec_r;

      // Saturation gating lives here too so a stalled issue can never bump the count.
      assign inc_r = iss_valid && (iss_addr == AW'(r)) && !sat[r];
      assign dec_r = wb_valid && wb_retire && (wb_addr == AW'(r));

      regfile_pend_cnt #(.W(PEND_W)) u_cnt (
         .clk (clk),
         .rst (rst),
         .inc (inc_r),
         .dec (dec_r),
         .clr (flush),
         .cnt (cnt[r]),
         .sat (sat[r]),
         .nz  (nz[r])
      );
   end

   assign iss_ready = (iss_addr == AW'(ZERO_REG)) || (cnt[iss_addr] != {PEND_W{1'b1}});

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = rd_addr[i*AW +: AW];
      assign rd_data[i*XLEN +: XLEN] =
         (ra == AW'(ZERO_REG))                           ? '0      :
         ((BYPASS != 0) && wb_valid && (wb_addr == ra))  ? wb_data :
                                                           regs_q[ra];
      // Busy is left set during a same-cycle bypass; the consumer decides.
      assign rd_busy[i] = nz[ra];
   end

   for (genvar r = 0; r < NREGS; r++) begin : g_dbg
      if (r == ZERO_REG) begin : g_zero
         assign dbg_regs[r*XLEN +: XLEN] = '0;
      end else begin : g_reg
         assign dbg_regs[r*XLEN +: XLEN] = regs_q[r];
      end
   end

`ifndef SYNTHESIS
   // Retiring a writeback that was never issued means the pipeline lost track of a hazard.
   always_ff @(posedge clk) begin
      if (rst && wb_valid && wb_retire && wb_addr != AW'(ZERO_REG)) begin
         assert (nz[wb_addr]);
      end
   end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: driver pushes expected outputs from a reference model, monitor pops and compares.
module tb_regfile_scoreboard;

  logic         clk;
  logic         rst;
  logic [7:0]   rd_addr;
  logic [63:0]  rd_data, rd_data_nb;
  logic [1:0]   rd_busy, rd_busy_nb;
  logic         iss_valid;
  logic [3:0]   iss_addr;
  logic         iss_ready, iss_ready_nb;
  logic         wb_valid;
  logic [3:0]   wb_addr;
  logic [31:0]  wb_data;
  logic         wb_retire;
  logic         flush;
  logic [511:0] dbg_regs, dbg_nb;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_retire(wb_retire),
    .flush(flush), .dbg_regs(dbg_regs)
  );

  regfile_scoreboard #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready_nb),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_retire(wb_retire),
    .flush(flush), .dbg_regs(dbg_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  rd;
    logic [63:0]  rd_nb;
    logic [1:0]   busy;
    logic         rdy;
    logic [511:0] dbg;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural values and outstanding-write counts.
  logic [31:0] m_regs [16];
  int          m_pend [16];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  exp_t e_mon;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e_mon = q.pop_front();
      chk("rd_data",      512'(rd_data),      512'(e_mon.rd));
      chk("rd_data_nb",   512'(rd_data_nb),   512'(e_mon.rd_nb));
      chk("rd_busy",      512'(rd_busy),      512'(e_mon.busy));
      chk("rd_busy_nb",   512'(rd_busy_nb),   512'(e_mon.busy));
      chk("iss_ready",    512'(iss_ready),    512'(e_mon.rdy));
      chk("iss_ready_nb", 512'(iss_ready_nb), 512'(e_mon.rdy));
      chk("dbg_regs",     dbg_regs,           e_mon.dbg);
      chk("dbg_regs_nb",  dbg_nb,             e_mon.dbg);
    end
  end

  function automatic logic [31:0] rexp(input logic [3:0] a, input bit byp, input logic wv,
                                       input logic [3:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (byp && wv && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic bit m_ready(input logic [3:0] a);
    return (a == 0) || (m_pend[a] != 3);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      m_regs[r] = 32'h0;
      m_pend[r] = 0;
    end
  endtask

  // One clock: drive inputs, queue expected outputs, then advance the model past the edge.
  task automatic cyc(input logic r, input logic iv, input logic [3:0] ia,
                     input logic wv, input logic [3:0] wa, input logic [31:0] wd,
                     input logic wr, input logic fl, input logic [3:0] a0, input logic [3:0] a1);
    exp_t e;
    bit   rdy;
    bit   do_inc, do_dec;
    rst = r; iss_valid = iv; iss_addr = ia; wb_valid = wv; wb_addr = wa;
    wb_data = wd; wb_retire = wr; flush = fl; rd_addr = {a1, a0};
    rdy     = m_ready(ia);
    e.rd    = {rexp(a1, 1, wv, wa, wd), rexp(a0, 1, wv, wa, wd)};
    e.rd_nb = {rexp(a1, 0, wv, wa, wd), rexp(a0, 0, wv, wa, wd)};
    e.busy  = {m_pend[a1] != 0, m_pend[a0] != 0};
    e.rdy   = rdy;
    for (int k = 0; k < 16; k++) e.dbg[k*32 +: 32] = m_regs[k];
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!r) begin
      model_reset();
    end else begin
      if (wv && wa != 0) m_regs[wa] = wd;
      if (fl) begin
        for (int k = 0; k < 16; k++) m_pend[k] = 0;
      end else begin
        do_inc = iv && rdy && ia != 0;
        do_dec = wv && wr && wa != 0 && m_pend[wa] > 0;
        if (do_inc) m_pend[ia] = m_pend[ia] + 1;
        if (do_dec) m_pend[wa] = m_pend[wa] - 1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          hold;
    logic [3:0]  hold_a;
    logic        r, iv, wv, wr, fl;
    logic [3:0]  ia, wa, a0, a1;
    logic [31:0] wd;

    rst = 1'b0; iss_valid = 0; iss_addr = 0; wb_valid = 0; wb_addr = 0;
    wb_data = 0; wb_retire = 0; flush = 0; rd_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Random writes, then two reset cycles.
    for (int k = 1; k < 6; k++) cyc(1, 1, 4'(k), 1, 4'(k + 1), $urandom, 0, 0, 4'(k), 4'(k + 1));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 2, 3);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 2, 3);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 2, 3);

    // Write/read and register 0.
    cyc(1, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 32'h12345678, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 5, 0);

    // Bypass and the no-bypass instance.
    cyc(1, 0, 0, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 7);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 7);

    // Pending counter saturation and stall.
    repeat (3) cyc(1, 1, 3, 0, 0, 0, 0, 0, 3, 0);
    repeat (2) cyc(1, 1, 3, 0, 0, 0, 0, 0, 3, 0);
    cyc(1, 0, 3, 1, 3, 32'h33, 1, 0, 3, 0);
    cyc(1, 0, 3, 1, 3, 32'h34, 1, 0, 3, 0);
    cyc(1, 0, 3, 1, 3, 32'h35, 1, 0, 3, 0);
    cyc(1, 0, 3, 0, 0, 0, 0, 0, 3, 0);

    // Simultaneous inc/dec, then flush with an issue and a data write.
    cyc(1, 1, 4, 0, 0, 0, 0, 0, 4, 0);
    cyc(1, 1, 4, 1, 4, 32'h44, 1, 0, 4, 0);
    cyc(1, 1, 9, 1, 10, 32'h1010, 0, 1, 4, 9);
    cyc(1, 0, 9, 0, 0, 0, 0, 0, 9, 10);
    cyc(1, 0, 4, 0, 0, 0, 0, 0, 4, 10);

    // Reset in the middle of outstanding writes.
    repeat (2) cyc(1, 1, 2, 0, 0, 0, 0, 0, 2, 0);
    cyc(0, 0, 2, 1, 2, 32'h55, 1, 0, 2, 0);
    cyc(1, 0, 2, 0, 0, 0, 0, 0, 2, 0);

    // Randomized traffic honouring the hold-while-stalled issue protocol.
    hold = 0;
    hold_a = 0;
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 49) != 0);
      fl = ($urandom_range(0, 19) == 0);
      if (hold) begin
        iv = 1; ia = hold_a;
      end else begin
        iv = 1'($urandom_range(0, 1));
        ia = 4'($urandom_range(0, 7));
      end
      wv = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 7));
      wd = $urandom;
      wr = (m_pend[wa] > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      a0 = 4'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 7));
      hold   = iv && !m_ready(ia);
      hold_a = ia;
      cyc(r, iv, ia, wv, wa, wd, wr, fl, a0, a1);
    end

    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d expected 0 entries left", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
